pipe_register: RTL



---
 rtl/pipe_register_pkg.sv | 15 +
 rtl/pipe_register_stage.sv | 75 +++++++
 rtl/pipe_register.sv | 66 ++++++
 3 files changed

// File: rtl/pipe_register_pkg.sv
// Shared types and helpers for the elastic pipe_register and its stages.
package pipe_register_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } stage_st_e;

  // Occupancy counter width: must represent 0..2*depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// One elastic stage: main + skid register, registered upstream ready so the
// ready path is cut at every stage boundary.
module pipe_stage
  import pipe_register_pkg::*;
#(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  stage_st_e        state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             push, pop;

  assign dn_valid = (state_q != EMPTY);
  assign dn_data  = main_q;
  assign up_ready = rdy_q;
  assign push     = up_valid & rdy_q;
  assign pop      = dn_valid & dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (push) begin
        state_d = FULL;
        main_d  = up_data;
      end
      FULL: begin
        if (push && pop) begin
          main_d = up_data;
        end else if (push) begin
          state_d = SKID;
          skid_d  = up_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      SKID: if (pop) begin
        state_d = FULL;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // flush discards occupancy only; data registers keep whatever they hold
    if (flush) state_d = EMPTY;
    rdy_d = (state_d != SKID);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: rtl/pipe_register.sv
// DEPTH-stage elastic pipeline with flush and occupancy count.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter  int WIDTH = 35,
  parameter  int DEPTH = 2,
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  // Index i is the boundary in front of stage i; index DEPTH is the output.
  logic [DEPTH:0]            vld;
  logic [DEPTH:0]            rdy;
  logic [DEPTH:0][WIDTH-1:0] dat;

  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0];
  assign out_valid  = vld[DEPTH];
  assign out_data   = dat[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (vld[i]),
      .up_ready (rdy[i]),
      .up_data  (dat[i]),
      .dn_valid (vld[i+1]),
      .dn_ready (rdy[i+1]),
      .dn_data  (dat[i+1])
    );
  end

  logic          push_in, pop_out;
  logic [CW-1:0] count_q, count_d;

  assign push_in = in_valid & in_ready;
  assign pop_out = out_valid & out_ready;
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (flush)                 count_d = '0;
    else if (push_in && !pop_out) count_d = count_q + CW'(1);
    else if (pop_out && !push_in) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule
